// File: rtl/sr_bank_pkg.sv
// Shared definitions for the synchronous SR latch bank: conflict-policy codes,
// the per-channel command encoding and the cell update rule.
package sr_bank_pkg;

    localparam int MODE_RESET_DOM = 0;
    localparam int MODE_SET_DOM   = 1;
    localparam int MODE_TOGGLE    = 2;
    localparam int MODE_HOLD      = 3;

    // Encoded as the raw {S,R} pair so the filter can cast the pair directly.
    typedef enum logic [1:0] {
        CMD_HOLD = 2'b00,
        CMD_CLR  = 2'b01,
        CMD_SET  = 2'b10,
        CMD_BOTH = 2'b11
    } sr_cmd_t;

    function automatic logic next_q(input sr_cmd_t cmd, input logic q, input int mode);
        logic res;
        res = q;
        case (cmd)
            CMD_SET:  res = 1'b1;
            CMD_CLR:  res = 1'b0;
            CMD_BOTH: begin
                case (mode)
                    MODE_RESET_DOM: res = 1'b0;
                    MODE_SET_DOM:   res = 1'b1;
                    MODE_TOGGLE:    res = ~q;
                    default:        res = q;
                endcase
            end
            default:  res = q;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sr_input_filter.sv
// Single-channel stability qualifier: a {S,R} pair becomes a command only after
// it has been sampled unchanged on FILTER+1 consecutive edges.
module sr_input_filter
    import sr_bank_pkg::*;
#(
    parameter int FILTER = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    S,
    input  logic    R,
    output logic    cmd_valid,
    output sr_cmd_t cmd
);

    localparam int CW = (FILTER > 0) ? $clog2(FILTER + 1) : 1;
    localparam logic [CW-1:0] FILT_MAX  = CW'(FILTER);
    localparam logic [CW-1:0] FILT_QUAL = (FILTER > 0) ? CW'(FILTER - 1) : '0;

    logic [1:0]    pair;
    logic [1:0]    prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable;

    assign pair = {S, R};

    always_comb begin
        prev_d    = prev_q;
        cnt_d     = cnt_q;
        stable    = (pair == prev_q);
        if (!stable) begin
            prev_d = pair;
            cnt_d  = '0;
        end else if (cnt_q < FILT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
        cmd       = sr_cmd_t'(pair);
        // cnt counts stable edges before this one, so FILTER-1 means this is edge FILTER+1.
        cmd_valid = (FILTER == 0) ? 1'b1 : (stable && (cnt_q >= FILT_QUAL));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 2'b00;
            cnt_q  <= '0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/sr_latch_bank.sv
// Bank of CHANNELS clocked SR cells with input filtering and a shared S=R=1 policy.
// Optional SR_BANK_EVENT_EN adds registered one-cycle rise/fall event outputs.
module sr_latch_bank
    import sr_bank_pkg::*;
#(
    parameter int                  CHANNELS = 4,
    parameter int                  MODE     = 0,
    parameter int                  FILTER   = 2,
    parameter logic [CHANNELS-1:0] INIT     = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] S,
    input  logic [CHANNELS-1:0] R,
    output logic [CHANNELS-1:0] Q,
    output logic [CHANNELS-1:0] Qn,
    output logic [CHANNELS-1:0] conflict
`ifdef SR_BANK_EVENT_EN
    ,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
`endif
);

    logic [CHANNELS-1:0] cmd_valid;
    sr_cmd_t             cmd [CHANNELS];
    logic [CHANNELS-1:0] q_q, q_d;
    logic [CHANNELS-1:0] conflict_q, conflict_d;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        sr_input_filter #(.FILTER(FILTER)) u_filt (
            .clk       (clk),
            .reset     (reset),
            .S         (S[i]),
            .R         (R[i]),
            .cmd_valid (cmd_valid[i]),
            .cmd       (cmd[i])
        );
    end

    always_comb begin
        q_d        = q_q;
        conflict_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cmd_valid[i]) begin
                q_d[i]        = next_q(cmd[i], q_q[i], MODE);
                conflict_d[i] = (cmd[i] == CMD_BOTH);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q        <= INIT;
            conflict_q <= '0;
        end else begin
            q_q        <= q_d;
            conflict_q <= conflict_d;
        end
    end

    assign Q        = q_q;
    assign Qn       = ~q_q;
    assign conflict = conflict_q;

`ifdef SR_BANK_EVENT_EN
    logic [CHANNELS-1:0] rise_q, rise_d;
    logic [CHANNELS-1:0] fall_q, fall_d;

    // Events register alongside Q so each pulse lines up with the cycle Q changes.
    always_comb begin
        rise_d = q_d & ~q_q;
        fall_d = ~q_d & q_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`endif

endmodule
